// File: rtl/cle_key_sequencer.sv
// rtl/cle_key_sequencer.sv - CLE023 keyed PAL read sequencer (optional abort via CLE_SEQ_ABORT_EN)
module cle_key_sequencer #(
  parameter int STEPS     = 16,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [STEPS-1:0] expected,
`ifdef CLE_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [5:0]       step_idx,
  input  logic [3:0]       step_nib,
  output logic             sser_n,
  output logic             ba13,
  output logic             ba12,
  output logic [3:0]       ba_lo,
  output logic             br_w,
  output logic             pal_clk,
  input  logic             sdrd,
  output logic             busy,
  output logic             done,
  output logic [STEPS-1:0] resp,
  output logic             match
);

  localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [5:0]       step_q, step_d;
  logic [STEPS-1:0] resp_q, resp_d;
  logic             match_q, match_d;
  logic [3:0]       ba_lo_q, ba_lo_d;
  logic             active;
  logic             abort_hit;

  // Abort only matters while a sequence is on the bus; DONE already exits.
`ifdef CLE_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  // State and datapath registers; async reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      step_q  <= '0;
      resp_q  <= '0;
      match_q <= 1'b0;
      ba_lo_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      step_q  <= step_d;
      resp_q  <= resp_d;
      match_q <= match_d;
      ba_lo_q <= ba_lo_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    step_d  = step_q;
    resp_d  = resp_q;
    match_d = match_q;
    ba_lo_d = ba_lo_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = '0;
          step_d  = '0;
          resp_d  = '0;
          match_d = 1'b0;
        end
      end
      SETUP: begin
        // step_idx is only valid for the new step once SETUP is entered,
        // so the table entry is captured during the first SETUP cycle.
        if (cnt == '0) ba_lo_d = step_nib;
        if (cnt >= CW'(SETUP_CYC - 1)) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STROBE: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt >= CW'(HOLD_CYC - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SAMPLE: begin
        for (int i = 0; i < STEPS; i++) begin
          if (step_q == 6'(i)) resp_d[i] = sdrd;
        end
        if (step_q == 6'(STEPS - 1)) begin
          state_d = DONE;
          match_d = (resp_d == expected);
        end else begin
          state_d = SETUP;
          step_d  = step_q + 6'd1;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = DONE;
      cnt_d   = '0;
      step_d  = step_q;
      resp_d  = resp_q;
      match_d = 1'b0;
      ba_lo_d = ba_lo_q;
    end
  end

  // Bus and status outputs decoded from state.
  always_comb begin
    active   = (state == SETUP) || (state == STROBE) || (state == HOLD) || (state == SAMPLE);
    sser_n   = ~active;
    ba13     = 1'b0;
    ba12     = active;
    br_w     = 1'b1;
    pal_clk  = (state == STROBE);
    busy     = active;
    done     = (state == DONE);
    step_idx = step_q;
    resp     = resp_q;
    match    = match_q;
    if ((state == SETUP) && (cnt == '0)) begin
      ba_lo = step_nib;
    end else if (active) begin
      ba_lo = ba_lo_q;
    end else begin
      ba_lo = 4'd0;
    end
  end

endmodule

// File: tb/tb_cle_key_sequencer.sv
// tb/tb_cle_key_sequencer.sv - directed bench for cle_key_sequencer (abort case under CLE_SEQ_ABORT_EN)
module tb_cle_key_sequencer;

  localparam int STEPS = 4;
  localparam int SETUP_CYC = 2;
  localparam int HOLD_CYC = 2;
  localparam int RUN_CYC = STEPS * (SETUP_CYC + HOLD_CYC + 2) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [STEPS-1:0] expected = '0;
  logic             abort = 1'b0;
  logic [5:0]       step_idx;
  logic [3:0]       step_nib;
  logic             sser_n, ba13, ba12, br_w, pal_clk, sdrd, busy, done, match;
  logic [3:0]       ba_lo;
  logic [STEPS-1:0] resp;

  logic [3:0] tbl [4];
  logic [3:0] pat;
  int checks = 0;
  int errors = 0;
  bit aborting = 0;

  initial begin
    tbl[0] = 4'h5; tbl[1] = 4'hA; tbl[2] = 4'h9; tbl[3] = 4'h3;
    pat = 4'b1101;
  end

  assign step_nib = tbl[step_idx[1:0]];
  assign sdrd = pat[step_idx[1:0]];

  always #5 clk = ~clk;

  cle_key_sequencer #(.STEPS(STEPS), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
`ifdef CLE_SEQ_ABORT_EN
    .abort(abort),
`endif
    .step_idx(step_idx), .step_nib(step_nib), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba_lo(ba_lo), .br_w(br_w), .pal_clk(pal_clk), .sdrd(sdrd), .busy(busy), .done(done),
    .resp(resp), .match(match)
  );

  // Protocol monitor: address stability around each strobe, pulse count per run, steady select.
  logic [3:0] prev_ba_lo = '0, held = '0;
  logic       prev_sser = 1'b1, prev_busy = 1'b0;
  int         hold_left = 0;
  int         pulses = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_left = 0;
      pulses = 0;
    end else begin
      if (busy && !prev_busy) pulses = 0;
      if (prev_busy && busy && (sser_n !== prev_sser)) begin
        errors++;
        $display("FAIL sser_toggle sser_n=%b prev=%b", sser_n, prev_sser);
      end
      if (pal_clk) begin
        pulses++;
        checks++;
        if (prev_sser !== 1'b0 || ba_lo !== prev_ba_lo || ba_lo !== tbl[step_idx[1:0]]) begin
          errors++;
          $display("FAIL strobe_addr ba_lo=%h prev=%h want=%h", ba_lo, prev_ba_lo, tbl[step_idx[1:0]]);
        end
        held = ba_lo;
        hold_left = HOLD_CYC + 1;
      end else if (hold_left > 0 && !sser_n) begin
        if (ba_lo !== held) begin
          errors++;
          $display("FAIL hold_addr ba_lo=%h want=%h", ba_lo, held);
        end
        hold_left--;
      end else begin
        hold_left = 0;
      end
      if (done && !aborting) begin
        checks++;
        if (pulses != STEPS) begin
          errors++;
          $display("FAIL pulse_count got=%0d want=%0d", pulses, STEPS);
        end
      end
    end
    prev_ba_lo = ba_lo;
    prev_sser = sser_n;
    prev_busy = busy;
  end

  // Pulse start across one rising edge; returns at the negedge of cycle 1.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sser_n, ba13, ba12, ba_lo, br_w, pal_clk, busy, done, resp, match, step_idx} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL reset_values sser_n=%b ba12=%b ba_lo=%h br_w=%b pal_clk=%b busy=%b done=%b resp=%b match=%b step=%0d",
               sser_n, ba12, ba_lo, br_w, pal_clk, busy, done, resp, match, step_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match();
    int cyc;
    expected = 4'b1101;
    do_start();
    cyc = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL match_busy got=%b want=1", busy); end
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != RUN_CYC) begin errors++; $display("FAIL match_latency got=%0d want=%0d", cyc, RUN_CYC); end
    checks++;
    if (resp !== 4'b1101 || match !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL match_result resp=%b match=%b busy=%b want 1101/1/0", resp, match, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || match !== 1'b1) begin
      errors++;
      $display("FAIL match_after done=%b match=%b want 0/1", done, match);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    int width;
    expected = 4'b1111;
    do_start();
    checks++;
    if (match !== 1'b0) begin errors++; $display("FAIL mismatch_clear match=%b want=0", match); end
    cyc = 1;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    width = 0;
    while (done && width < 10) begin width++; @(negedge clk); end
    checks++;
    if (resp !== 4'b1101 || match !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_result resp=%b match=%b want 1101/0", resp, match);
    end
    checks++;
    if (width != 1) begin errors++; $display("FAIL done_width got=%0d want=1", width); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int changes;
    logic [5:0] last;
    expected = 4'b1101;
    do_start();
    cyc = 1;
    changes = 0;
    last = step_idx;
    while (!done && cyc < 100) begin
      start = (cyc == 3 || cyc == 10);
      @(negedge clk);
      cyc++;
      if (step_idx != last) begin
        changes++;
        if (step_idx != last + 6'd1) begin
          errors++;
          $display("FAIL step_order got=%0d after=%0d", step_idx, last);
        end
        last = step_idx;
      end
    end
    start = 1'b0;
    checks++;
    if (cyc != RUN_CYC || changes != 3 || last != 6'd3) begin
      errors++;
      $display("FAIL start_ignored cyc=%0d changes=%0d last=%0d want %0d/3/3", cyc, changes, last, RUN_CYC);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    do_start();
    cyc = 1;
    while (cyc < 15) begin @(negedge clk); cyc++; end
    checks++;
    if (pal_clk !== 1'b1 || step_idx !== 6'd2) begin
      errors++;
      $display("FAIL strobe_step2 pal_clk=%b step=%0d want 1/2", pal_clk, step_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pal_clk !== 1'b0 || sser_n !== 1'b1 || busy !== 1'b0 || step_idx !== 6'd0) begin
      errors++;
      $display("FAIL async_reset pal_clk=%b sser_n=%b busy=%b step=%0d want 0/1/0/0", pal_clk, sser_n, busy, step_idx);
    end
    @(negedge clk) rst_n = 1'b1;
    expected = 4'b1101;
    do_start();
    cyc = 1;
    checks++;
    if (step_idx !== 6'd0 || resp !== 4'd0) begin
      errors++;
      $display("FAIL rerun_start step=%0d resp=%b want 0/0000", step_idx, resp);
    end
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != RUN_CYC || resp !== 4'b1101 || match !== 1'b1) begin
      errors++;
      $display("FAIL rerun_result cyc=%0d resp=%b match=%b want %0d/1101/1", cyc, resp, match, RUN_CYC);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    expected = 4'b1101;
    do_start();
    cyc = 1;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done busy=%b done=%b want 0/0", busy, done);
    end
    do_start();
    cyc = 1;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != RUN_CYC || resp !== 4'b1101 || match !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back cyc=%0d resp=%b match=%b want %0d/1101/1", cyc, resp, match, RUN_CYC);
    end
    @(negedge clk);
  endtask

`ifdef CLE_SEQ_ABORT_EN
  task automatic test_abort();
    int cyc;
    expected = 4'b0001;
    aborting = 1;
    do_start();
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || match !== 1'b0 || resp !== 4'b0001 || pal_clk !== 1'b0) begin
      errors++;
      $display("FAIL abort_done done=%b match=%b resp=%b pal_clk=%b want 1/0/0001/0", done, match, resp, pal_clk);
    end
    @(negedge clk);
    aborting = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sser_n !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle busy=%b done=%b sser_n=%b want 0/0/1", busy, done, sser_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
`ifdef CLE_SEQ_ABORT_EN
    test_abort();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
